// File: rtl/hall_input_conditioner.sv
// Hall sensor front end: 2-flop synchronise, stable-time glitch filter, illegal-code
// rejection and sticky fault tracking ahead of the three-phase encoder.
module hall_input_conditioner #(
    parameter int CLK_FREQ_HZ  = 27_000_000,
    parameter int FILTER_TICKS = CLK_FREQ_HZ / 1_000_000,
    parameter int FAULT_TICKS  = FILTER_TICKS * 10,
    parameter int GLITCH_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    hall_a,
    input  logic                    hall_b,
    input  logic                    hall_c,
    input  logic                    fault_clear,
    output logic [2:0]              hall_values,
    output logic                    hall_valid,
    output logic                    hall_changed,
    output logic                    fault,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);
    localparam int SW = $clog2(FILTER_TICKS) + 1;
    localparam int FW = $clog2(FAULT_TICKS) + 1;
    localparam logic [SW-1:0] STABLE_MAX = SW'(FILTER_TICKS - 1);
    localparam logic [FW-1:0] FAULT_MAX  = FW'(FAULT_TICKS - 1);

    typedef enum logic [1:0] {ST_SETTLE, ST_TRACK, ST_INVALID, ST_FAULT} state_t;

    function automatic logic is_legal(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    logic [2:0]              r_sync1, r_sync2, r_cand, r_filt, r_hall;
    logic [SW-1:0]           r_stable;
    logic [FW-1:0]           r_fcnt;
    logic [GLITCH_WIDTH-1:0] r_glitch;
    logic                    r_valid, r_changed;
    state_t                  r_state, w_next_state;

    logic       w_cand_chg, w_accept, w_cand_legal;
    logic [2:0] w_filt_next;

    assign w_cand_chg   = (r_sync2 != r_cand);
    assign w_accept     = !w_cand_chg && (r_stable == STABLE_MAX) && (r_cand != r_filt);
    assign w_cand_legal = is_legal(r_cand);
    assign w_filt_next  = w_accept ? r_cand : r_filt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_cand    <= '0;
            r_filt    <= '0;
            r_hall    <= '0;
            r_stable  <= '0;
            r_glitch  <= '0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_sync1   <= {hall_a, hall_b, hall_c};
            r_sync2   <= r_sync1;
            r_changed <= 1'b0;
            if (w_cand_chg) begin
                r_cand   <= r_sync2;
                r_stable <= '0;
                // abandoning a pending change counts as a rejected glitch
                if ((r_cand != r_filt) && (r_glitch != '1))
                    r_glitch <= r_glitch + 1'b1;
            end else if (r_stable < STABLE_MAX) begin
                r_stable <= r_stable + 1'b1;
            end
            if (w_accept) begin
                r_filt  <= r_cand;
                r_valid <= w_cand_legal;
                if (w_cand_legal) begin
                    r_hall    <= r_cand;
                    r_changed <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_SETTLE, ST_TRACK: begin
                if (w_accept)
                    w_next_state = w_cand_legal ? ST_TRACK : ST_INVALID;
            end
            ST_INVALID: begin
                if (w_accept && w_cand_legal)
                    w_next_state = ST_TRACK;
                else if (r_fcnt == FAULT_MAX)
                    w_next_state = ST_FAULT;
            end
            ST_FAULT: begin
                if (fault_clear)
                    w_next_state = is_legal(w_filt_next) ? ST_TRACK : ST_INVALID;
            end
            default: w_next_state = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_SETTLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_INVALID) && (w_next_state == ST_INVALID))
                r_fcnt <= r_fcnt + 1'b1;
            else
                r_fcnt <= '0;
        end
    end

    assign hall_values  = r_hall;
    assign hall_valid   = r_valid;
    assign hall_changed = r_changed;
    assign fault        = (r_state == ST_FAULT);
    assign glitch_count = r_glitch;
endmodule

// File: tb/tb_hall_input_conditioner.sv
// Directed bench for hall_input_conditioner with FILTER_TICKS=4, FAULT_TICKS=8.
module tb_hall_input_conditioner;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hall_a = 1'b0, hall_b = 1'b0, hall_c = 1'b0;
    logic        fault_clear = 1'b0;
    logic [2:0]  hall_values;
    logic        hall_valid, hall_changed, fault;
    logic [15:0] glitch_count;

    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;
    int chg_base;
    logic [2:0] cw_seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    hall_input_conditioner #(
        .FILTER_TICKS(4), .FAULT_TICKS(8), .GLITCH_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .hall_a(hall_a), .hall_b(hall_b), .hall_c(hall_c),
        .fault_clear(fault_clear),
        .hall_values(hall_values), .hall_valid(hall_valid),
        .hall_changed(hall_changed), .fault(fault),
        .glitch_count(glitch_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (hall_changed) chg_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] code);
        {hall_a, hall_b, hall_c} = code;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick(2);
        check("rst_values", 32'(hall_values), 32'h0);
        check("rst_valid", 32'(hall_valid), 32'h0);
        check("rst_changed", 32'(hall_changed), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_glitch", 32'(glitch_count), 32'h0);
        reset_n = 1'b1;
        tick(2);

        // first acceptance: E0+6 latency
        drive(3'b100);
        tick(6);
        check("acc_early_values", 32'(hall_values), 32'h0);
        check("acc_early_changed", 32'(hall_changed), 32'h0);
        tick(1);
        check("acc_values", 32'(hall_values), 32'h4);
        check("acc_valid", 32'(hall_valid), 32'h1);
        check("acc_changed", 32'(hall_changed), 32'h1);
        tick(1);
        check("acc_changed_drop", 32'(hall_changed), 32'h0);
        check("acc_glitch", 32'(glitch_count), 32'h0);

        // 2-cycle glitch to 110 is rejected
        chg_base = chg_cnt;
        drive(3'b110);
        tick(2);
        drive(3'b100);
        tick(10);
        check("glitch_values", 32'(hall_values), 32'h4);
        check("glitch_no_change", 32'(chg_cnt - chg_base), 32'h0);
        check("glitch_count1", 32'(glitch_count), 32'h1);

        // illegal 000 accepted, fault 8 cycles after hall_valid falls
        drive(3'b000);
        tick(7);
        check("ill_valid", 32'(hall_valid), 32'h0);
        check("ill_values", 32'(hall_values), 32'h4);
        check("ill_fault_early", 32'(fault), 32'h0);
        tick(7);
        check("ill_fault_7", 32'(fault), 32'h0);
        tick(1);
        check("ill_fault_8", 32'(fault), 32'h1);

        // clear while still illegal: fault re-asserts after 8 cycles
        tick(3);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("clr_ill_drop", 32'(fault), 32'h0);
        tick(7);
        check("clr_ill_still_low", 32'(fault), 32'h0);
        tick(1);
        check("clr_ill_reassert", 32'(fault), 32'h1);

        // legal code while in fault: outputs update, fault stays until clear
        drive(3'b010);
        tick(7);
        check("flt_legal_values", 32'(hall_values), 32'h2);
        check("flt_legal_changed", 32'(hall_changed), 32'h1);
        check("flt_legal_fault", 32'(fault), 32'h1);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("clr_legal_fault", 32'(fault), 32'h0);
        check("clr_legal_values", 32'(hall_values), 32'h2);
        check("clr_legal_valid", 32'(hall_valid), 32'h1);
        tick(10);
        check("clr_legal_stays", 32'(fault), 32'h0);

        // full CW rotation
        chg_base = chg_cnt;
        for (int i = 0; i < 6; i++) begin
            drive(cw_seq[i]);
            tick(10);
            check($sformatf("cw_values_%0d", i), 32'(hall_values), 32'(cw_seq[i]));
        end
        check("cw_pulses", 32'(chg_cnt - chg_base), 32'd6);
        check("cw_fault", 32'(fault), 32'h0);
        check("cw_valid", 32'(hall_valid), 32'h1);

        // reset while a change to 011 is pending with stable=2
        drive(3'b011);
        tick(5);
        reset_n = 1'b0;
        #1;
        check("mid_rst_values", 32'(hall_values), 32'h0);
        check("mid_rst_valid", 32'(hall_valid), 32'h0);
        check("mid_rst_fault", 32'(fault), 32'h0);
        check("mid_rst_glitch", 32'(glitch_count), 32'h0);
        tick(3);
        reset_n = 1'b1;
        tick(6);
        check("rel_early_values", 32'(hall_values), 32'h0);
        tick(1);
        check("rel_values", 32'(hall_values), 32'h3);
        check("rel_changed", 32'(hall_changed), 32'h1);
        check("rel_valid", 32'(hall_valid), 32'h1);

        // glitch counter saturation: >65535 abandoned pending changes
        tick(4);
        for (int i = 0; i < 65540; i++) begin
            drive(i[0] ? 3'b010 : 3'b110);
            tick(1);
        end
        drive(3'b011);
        tick(10);
        check("sat_glitch", 32'(glitch_count), 32'hFFFF);
        check("sat_values", 32'(hall_values), 32'h3);
        check("sat_fault", 32'(fault), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
